// File: rtl/sync_fifo_flags.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// almost-full/empty thresholds, fill count, sticky overflow/underflow and sync flush.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int SIZE      = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = (2 ** SIZE) - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             flush,
  input  logic             w_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             r_en,
  output logic [WIDTH-1:0] data_out,
  output logic             r_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [SIZE:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 2 ** SIZE;
  localparam logic [SIZE:0] PTR_ONE   = (SIZE + 1)'(1);
  localparam logic [SIZE:0] DEPTH_C   = (SIZE + 1)'(DEPTH);
  localparam logic [SIZE:0] AFULL_C   = (SIZE + 1)'(AFULL_TH);
  localparam logic [SIZE:0] AEMPTY_C  = (SIZE + 1)'(AEMPTY_TH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SIZE:0]    r_wr_ptr;
  logic [SIZE:0]    r_rd_ptr;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_head;

  // Pointers carry one extra MSB so full (DEPTH) and empty (0) stay distinct.
  assign count        = r_wr_ptr - r_rd_ptr;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  assign w_wr_acc = w_en && !full;
  assign w_rd_acc = r_en && !empty;
  assign w_head   = r_mem[r_rd_ptr[SIZE-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_en && full)  r_overflow  <= 1'b1;
      if (r_en && empty) r_underflow <= 1'b1;
    end
  end

  // NOTE: storage array is deliberately not reset; arst_n gating blocks a write on a reset edge.
  always_ff @(posedge clk) begin
    if (arst_n && !flush && w_wr_acc) r_mem[r_wr_ptr[SIZE-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : w_head;
      assign r_valid  = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] r_data;
      logic             r_rvalid;

      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          r_data   <= '0;
          r_rvalid <= 1'b0;
        end else if (flush) begin
          r_data   <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd_acc;
          if (w_rd_acc) r_data <= w_head;
        end
      end

      assign data_out = r_data;
      assign r_valid  = r_rvalid;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: standard and FWFT instances share stimulus; a queue model
// predicts every cycle and a monitor compares both instances against it.
module tb_sync_fifo_flags;

  localparam int W = 8;
  localparam int S = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  logic arst_n, flush, w_en, r_en;
  logic [W-1:0] data_in;

  logic [W-1:0] s_dout, f_dout;
  logic s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [S:0] s_cnt, f_cnt;

  always #5 clk = ~clk;

  sync_fifo_flags #(.WIDTH(W), .SIZE(S), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)) u_std (
    .clk(clk), .arst_n(arst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(s_dout), .r_valid(s_rv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_unf));

  sync_fifo_flags #(.WIDTH(W), .SIZE(S), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)) u_fwft (
    .clk(clk), .arst_n(arst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(f_dout), .r_valid(f_rv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_unf));

  typedef struct {
    int         cnt;
    bit         ovf, unf, rv_std;
    logic [W-1:0] dout_std, dout_fwft;
  } snap_t;

  // Reference model state: contents as a plain queue plus sticky bits.
  logic [W-1:0] m_q [$];
  bit           m_ovf, m_unf;
  logic [W-1:0] m_last;
  snap_t        exp_q [$];
  logic [W-1:0] exp_rd_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_last = '0;
  endtask

  task automatic model_edge(input logic w, input logic r, input logic fl, input logic [W-1:0] d);
    snap_t s;
    bit    rd;
    int    n;
    rd = 1'b0;
    n  = m_q.size();
    if (fl) begin
      model_reset();
    end else begin
      if (w && n == D) m_ovf = 1'b1;
      if (r && n == 0) m_unf = 1'b1;
      if (r && n > 0) begin
        m_last = m_q.pop_front();
        exp_rd_q.push_back(m_last);
        rd = 1'b1;
      end
      if (w && n < D) m_q.push_back(d);
    end
    s.cnt       = m_q.size();
    s.ovf       = m_ovf;
    s.unf       = m_unf;
    s.rv_std    = rd;
    s.dout_std  = m_last;
    s.dout_fwft = (m_q.size() > 0) ? m_q[0] : '0;
    exp_q.push_back(s);
  endtask

  task automatic step(input logic w, input logic r, input logic fl, input logic [W-1:0] d);
    @(negedge clk);
    w_en = w; r_en = r; flush = fl; data_in = d;
    @(posedge clk);
    model_edge(w, r, fl, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cnt"},   {s_cnt, f_cnt}, '0);
    check({tag, "_empty"}, {s_empty, f_empty, s_ae, f_ae}, 4'hF);
    check({tag, "_full"},  {s_full, f_full, s_af, f_af}, '0);
    check({tag, "_flags"}, {s_ovf, f_ovf, s_unf, f_unf}, '0);
    check({tag, "_valid"}, {s_rv, f_rv}, '0);
    check({tag, "_dout"},  {s_dout, f_dout}, '0);
  endtask

  // Monitor: compares every predicted cycle; pops read data whenever r_valid is shown.
  initial begin
    snap_t s;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check("count",        {s_cnt, f_cnt}, {3'(s.cnt), 3'(s.cnt)});
        check("full",         {s_full, f_full}, {2{s.cnt == D}});
        check("empty",        {s_empty, f_empty}, {2{s.cnt == 0}});
        check("almost_full",  {s_af, f_af}, {2{s.cnt >= 3}});
        check("almost_empty", {s_ae, f_ae}, {2{s.cnt <= 1}});
        check("overflow",     {s_ovf, f_ovf}, {2{s.ovf}});
        check("underflow",    {s_unf, f_unf}, {2{s.unf}});
        check("std_rvalid",   s_rv, s.rv_std);
        check("std_dout_hold", s_dout, s.dout_std);
        check("fwft_rvalid",  f_rv, s.cnt != 0);
        check("fwft_dout",    f_dout, s.dout_fwft);
        if (s_rv) begin
          if (exp_rd_q.size() == 0) check("std_spurious_rvalid", 1, 0);
          else check("std_rdata_order", s_dout, exp_rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    arst_n = 1'b0; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    model_reset();
    #1;
    check_reset_outputs("por");
    #20;
    @(negedge clk) arst_n = 1'b1;

    // Fill past full: 5th write dropped, overflow set.
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 8'hA0 + 8'(i));
    // Drain past empty: underflow set, data_out holds last word.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);

    // Single word: FWFT shows it with no r_en, then pop.
    step(1, 0, 0, 8'h5C);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);

    // Simultaneous read/write at count 2 across pointer wrap.
    step(1, 0, 0, 8'hB0);
    step(1, 0, 0, 8'hB1);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 8'hC0 + 8'(i));
    // Simultaneous at full: write dropped, count 3.
    step(1, 0, 0, 8'hD0);
    step(1, 0, 0, 8'hD1);
    step(1, 1, 0, 8'hEE);
    // Back to full, overflow, then down to 3 and flush with a write pending.
    step(1, 0, 0, 8'hD2);
    step(1, 0, 0, 8'hD3);
    step(0, 1, 0, 8'h00);
    step(1, 0, 1, 8'h77);
    step(0, 0, 0, 8'h00);

    // Asynchronous reset mid-burst.
    step(1, 0, 0, 8'h11);
    step(1, 1, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    @(negedge clk);
    #2;
    w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    exp_rd_q.delete();
    @(negedge clk);
    @(negedge clk) arst_n = 1'b1;
    step(0, 0, 0, 8'h00);

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 99) < 55), logic'($urandom_range(0, 99) < 50),
           logic'($urandom_range(0, 99) < 3), 8'($urandom));
    step(0, 0, 0, 8'h00);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size() + exp_rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
